// File: rtl/ysyx_25020037_gpr_sb.sv
// ---------------------------------------------------------------------------
// ysyx_25020037_gpr_sb
//
// General-purpose register file with an integrated scoreboard for a simple
// in-order RISC-V pipeline. Each architectural register has a data word and
// a busy bit. The busy bit is set when an instruction that will write the
// register is issued, and cleared when that instruction writes back. Readers
// use the per-port busy flag to decide whether the operand is ready. A
// writeback in the same cycle as a read is forwarded, so the reader sees
// the new value and no busy flag.
//
// Parameters
//   DATA_W : register width in bits
//   NREGS  : architectural register count (16 for RV32E, 32 for RV32I)
//   NRP    : number of combinational read ports (1..4)
//
// Ports
//   clk       : single clock; all state changes on the rising edge
//   rst       : synchronous active-high reset (clears data, busy, count)
//   rd_addr   : packed read addresses, port k at [k*AW +: AW]
//   rd_data   : packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy   : per-port flag, operand not yet available
//   wr_en     : writeback enable
//   wr_addr   : writeback destination register
//   wr_data   : writeback data
//   iss_en    : issue request reserving iss_rd
//   iss_rd    : destination register being reserved
//   iss_ready : issue is accepted this cycle when iss_en is high
//   flush     : drop every outstanding reservation
//   busy_cnt  : number of registers currently reserved
// ---------------------------------------------------------------------------
module ysyx_25020037_gpr_sb #(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 32,
  parameter  int NRP    = 2,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRP*AW-1:0]     rd_addr,
  output logic [NRP*DATA_W-1:0] rd_data,
  output logic [NRP-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_rd,
  output logic                  iss_ready,
  input  logic                  flush,
  output logic [AW:0]           busy_cnt
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  logic [AW:0]       cnt_next;

  // -------------------------------------------------------------------------
  // Qualified events for this cycle
  // -------------------------------------------------------------------------
  logic wr_fire;   // writeback that actually targets a real register
  logic iss_fire;  // issue accepted this cycle
  logic set_fire;  // accepted issue that reserves a real register
  logic set_new;   // reservation turns a free register busy
  logic clr_real;  // writeback frees a register that stays free

  assign wr_fire  = wr_en && (wr_addr != '0);
  assign iss_fire = iss_en && iss_ready;
  assign set_fire = iss_fire && (iss_rd != '0);

  // A destination already reserved may be re-issued only when its pending
  // writeback lands this very cycle; flush blocks all new reservations so
  // nothing survives the flush edge.
  assign iss_ready = !flush &&
                     ((iss_rd == '0) || !busy[iss_rd] ||
                      (wr_en && (wr_addr == iss_rd)));

  // Counter deltas are derived from real bit transitions, so a set and a
  // clear of the same register cancel out and clearing a free register is
  // a no-op.
  assign set_new  = set_fire && !busy[iss_rd];
  assign clr_real = wr_fire && busy[wr_addr] &&
                    !(set_fire && (iss_rd == wr_addr));

  // -------------------------------------------------------------------------
  // Read ports with write bypass
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = rd_addr[k*AW +: AW];
    assign hit  = wr_fire && (wr_addr == addr);

    assign rd_data[k*DATA_W +: DATA_W] = hit            ? wr_data :
                                         (addr == '0)   ? '0      :
                                                          regs[addr];
    assign rd_busy[k] = busy[addr] && !hit;
  end

  // -------------------------------------------------------------------------
  // Next-state busy vector and count
  // -------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so later statements override earlier ones and
  // no latch is inferred.
  always_comb begin
    busy_next = busy;
    cnt_next  = busy_cnt + (AW+1)'(set_new) - (AW+1)'(clr_real);
    if (wr_fire)  busy_next[wr_addr] = 1'b0;
    if (set_fire) busy_next[iss_rd]  = 1'b1;  // set wins over clear
    busy_next[0] = 1'b0;
    if (flush) begin
      busy_next = '0;
      cnt_next  = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Sequential update
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register array is built from flops, not a RAM macro, so
      // clearing every entry on reset is both legal and required here.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_fire) regs[wr_addr] <= wr_data;
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

endmodule

// File: doc/ysyx_25020037_gpr_sb.md
YSYX_25020037_GPR_SB -- requirements
Module: ysyx_25020037_gpr_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 SHALL have parameter NREGS, default 32, meaning architectural register count (legal values 16 for RV32E or 32); AW = clog2(NREGS).
REQ-003 SHALL have parameter NRP, default 2, meaning read-port count (legal values 1..4).
REQ-004 SHALL provide port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-005 SHALL provide port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL provide port rd_addr, input, NRP*AW, packed read addresses, port k at bits [k*AW +: AW].
REQ-007 SHALL provide port rd_data, output, NRP*DATA_W, packed read data, port k at bits [k*DATA_W +: DATA_W].
REQ-008 SHALL provide port rd_busy, output, NRP, per-port flag: the operand is not yet available.
REQ-009 SHALL provide port wr_en, input, 1, writeback enable.
REQ-010 SHALL provide port wr_addr, input, AW, writeback destination.
REQ-011 SHALL provide port wr_data, input, DATA_W, writeback data.
REQ-012 SHALL provide port iss_en, input, 1, issue request that reserves a destination.
REQ-013 SHALL provide port iss_rd, input, AW, destination register being reserved.
REQ-014 SHALL provide port iss_ready, output, 1, issue is accepted this cycle.
REQ-015 SHALL provide port flush, input, 1, discard all outstanding reservations.
REQ-016 SHALL provide port busy_cnt, output, AW+1, number of registers currently reserved.

Function
REQ-017 SHALL hold NREGS registers of DATA_W bits; register 0 SHALL always read 0 and SHALL ignore writes.
REQ-018 SHALL perform a writeback when wr_en=1 and wr_addr!=0; the register SHALL be updated at the next rising edge.
REQ-019 SHALL make each read port combinational; when wr_en=1, wr_addr!=0 and wr_addr==rd_addr[k], rd_data[k] SHALL equal wr_data in the same cycle (write bypass).
REQ-020 SHALL keep one busy bit per register; bit 0 SHALL be constant 0.
REQ-021 SHALL drive rd_busy[k]=1 iff busy[rd_addr[k]]=1 and no bypassing writeback to rd_addr[k] occurs this cycle.
REQ-022 SHALL drive iss_ready = (iss_rd==0) | ~busy[iss_rd] | (wr_en & wr_addr==iss_rd), and SHALL force it to 0 while flush=1.
REQ-023 SHALL treat issue as accepted when iss_en & iss_ready; an accepted issue with iss_rd!=0 SHALL set busy[iss_rd] at the next edge.
REQ-024 SHALL clear busy[wr_addr] at the next edge on a writeback, unless an accepted issue targets the same register that cycle; in that case the set wins and busy stays 1.
REQ-025 SHALL commit writeback data even when the target is not busy, and SHALL leave its busy bit unchanged in that case.
REQ-026 SHALL ignore an issue that is not accepted, with no state change.
REQ-027 SHALL, on flush=1, clear all busy bits and set busy_cnt to 0 at the next edge; a writeback in the same cycle SHALL still update data.
REQ-028 SHALL update busy_cnt registered, by +1 on a set only, -1 on a clear only, and unchanged for set+clear on the same register or set+clear on different registers; busy_cnt SHALL never exceed NREGS-1 nor wrap below 0.
REQ-029 SHALL make busy_cnt always equal the population count of the busy bits.

Reset
REQ-030 SHALL, while rst=1 at a rising edge, clear all registers to 0, clear all busy bits and set busy_cnt to 0; rst SHALL take priority over flush, issue and writeback.
REQ-031 SHALL drive rd_data of every port to 0, rd_busy to 0 and iss_ready to 1 in the first cycle after reset.

Verification
REQ-032 SHALL be tested as follows: write x5=0xDEADBEEF, with rd_addr[0]=5 in the same cycle -> rd_data[0]=0xDEADBEEF in that cycle; the next cycle also reads 0xDEADBEEF.
REQ-033 SHALL be tested as follows: write x0=0x1234 and issue iss_rd=0 -> x0 reads 0, busy_cnt stays 0, and iss_ready=1.
REQ-034 SHALL be tested as follows: issue x7, then read x7 -> rd_busy=1 and busy_cnt=1; a second issue to x7 sees iss_ready=0 and is ignored; a writeback to x7=0x55 gives bypass 0x55 with rd_busy=0, and the next cycle busy_cnt=0.
REQ-035 SHALL be tested as follows: writeback to x9 while issuing x9 in the same cycle -> x9 data updated, busy[x9]=1, and busy_cnt unchanged (+1 if x9 was not previously busy).
REQ-036 SHALL be tested as follows: issue x1,x2,x3 on consecutive cycles, then flush with a concurrent writeback x4=7 -> busy_cnt=0, all rd_busy=0, and x4 reads 7.
REQ-037 SHALL be tested as follows: with NREGS=16 and NRP=4, fill all registers, assert rst mid-operation -> all ports read 0 and busy_cnt=0 on the next cycle.
